fpu_sequencer: RTL and testbench
================================

FPU_SEQUENCER -- requirements
Module: fpu_sequencer

Interface
REQ-001 SHALL have parameter LAT_FMA, default 3: EXEC cycles for FMADD/FMSUB/FNMSUB/FNMADD.
REQ-002 SHALL have parameter LAT_ARITH, default 2: EXEC cycles for FADD/FSUB/FMUL.
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port reqValid_i, input, 1: core offers an FP instruction.
REQ-006 SHALL have port reqReady_o, output, 1: sequencer can accept a request.
REQ-007 SHALL have ports instr_i, rs1_i, rs2_i and rs3_i, input, 32 each: instruction word and operands.
REQ-008 SHALL have port frm_i, input, 3: dynamic rounding mode from the fcsr.
REQ-009 SHALL have port flush_i, input, 1: kill any request being accepted or in flight.
REQ-010 SHALL have ports fpuEnable_o (1), fpuInstr_o (32), fpuRs1_o, fpuRs2_o and fpuRs3_o (32 each), and fpuRm_o (3), outputs: registered drive to the FPU.
REQ-011 SHALL have port fpuOut_i, input, 32: FPU combinational result.
REQ-012 SHALL have port fpuBusy_i, input, 1: FPU stall.
REQ-013 SHALL have port rspValid_o, output, 1: result available.
REQ-014 SHALL have port rspReady_i, input, 1: core consumes the result.
REQ-015 SHALL have port rspData_o, output, 32: result.
REQ-016 SHALL have port rspRd_o, output, 5: destination register, instr[11:7].
REQ-017 SHALL have port rspToInt_o, output, 1: result targets the integer register file.
REQ-018 SHALL have port rspIllegal_o, output, 1: unsupported op or invalid rounding mode.

Function
REQ-019 SHALL implement the states IDLE, EXEC and RESP.
REQ-020 SHALL drive reqReady_o=1 only in IDLE.
REQ-021 SHALL accept a request when reqValid_i and reqReady_o are both high and flush_i is low.
REQ-022 SHALL, on accept, register instr and the three operands, load the latency counter and go IDLE->EXEC.
REQ-023 SHALL select the latency as follows:
- instr[4]=0: LAT_FMA.
- funct5 00000, 00001 or 00010: LAT_ARITH.
- everything else: 1.
REQ-024 SHALL, on accept, set fpuRm_o to frm_i when instr[14:12]=111 and to instr[14:12] otherwise.
REQ-025 SHALL flag illegal when the resolved rm is 101, 110 or 111.
REQ-026 SHALL flag illegal for FDIV (funct5 00011) and FSQRT (funct5 01011); the result is then 0.
REQ-027 SHALL drive fpuEnable_o=1 throughout EXEC and 0 otherwise; the fpu* operand outputs SHALL be stable for all of EXEC.
REQ-028 SHALL decrement the counter each EXEC cycle with fpuBusy_i=0 and hold it while fpuBusy_i=1.
REQ-029 SHALL, in the EXEC cycle where the counter=1 and fpuBusy_i=0, capture fpuOut_i into rspData_o and go EXEC->RESP.
REQ-030 SHALL, for a request accepted in cycle T with no stalls, assert rspValid_o in cycle T+L+1.
REQ-031 SHALL hold rspValid_o and the rsp* outputs stable in RESP until rspReady_i=1, then go RESP->IDLE.
REQ-032 SHALL accept the next request no earlier than the cycle after the RESP handshake (one bubble).
REQ-033 SHALL set rspToInt_o=1 for non-FMA funct5 10100, 11100 or 11000.
REQ-034 SHALL, on flush_i=1 in EXEC or RESP, go to IDLE next cycle with rspValid_o=0 and fpuEnable_o=0; no response is produced.
REQ-035 SHALL give flush_i priority over rspReady_i and over reqValid_i.
REQ-036 SHALL leave the counter value irrelevant outside EXEC.

Reset
REQ-037 SHALL, on reset_i=1 at a clock edge, go to IDLE.
REQ-038 SHALL reset reqReady_o=1 from the next cycle.
REQ-039 SHALL reset fpuEnable_o, rspValid_o, rspToInt_o and rspIllegal_o to 0.
REQ-040 SHALL reset rspData_o, rspRd_o, fpuInstr_o, fpuRs1/2/3_o and fpuRm_o to 0.
REQ-041 SHALL, on reset mid-EXEC or mid-RESP, discard the operation with no response.

Structure
REQ-042 SHALL take from shared package fpu_pkg: funct5 constants, the state enum, the latency-class enum and the rm-encoding constants.
REQ-043 SHALL contain one combinational sub-module, fpu_op_decode: instr + frm to latency class, toInt, illegal and resolved rm.

Verification
REQ-044 SHALL cover: fadd.s f3,f1,f2 (instr 0x002081D3), rs1=0x3F800000, rs2=0x40000000, accepted in T -> rspValid_o at T+3, rspData_o=0x40400000, rspRd_o=3, rspToInt_o=0.
REQ-045 SHALL cover: FMADD accepted in T with fpuBusy_i=1 for 2 EXEC cycles -> rspValid_o at T+6, and fpuEnable_o high for 5 cycles.
REQ-046 SHALL cover: instr rm=111 with frm_i=010 -> fpuRm_o=010; frm_i=101 -> rspIllegal_o=1.
REQ-047 SHALL cover: feq.s -> latency 1, rspToInt_o=1; rspReady_i=0 for 4 cycles -> rsp outputs held, reqReady_o=0.
REQ-048 SHALL cover: flush_i in the second EXEC cycle of FMUL -> rspValid_o never 1, reqReady_o=1 next cycle.
REQ-049 SHALL cover: reset_i asserted in RESP -> rspValid_o=0 next cycle; FDIV -> rspIllegal_o=1, rspData_o=0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FP sequencer definitions: FSM states, latency classes, funct5 and rounding-mode encodings.
package fpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seqState_t;

  typedef enum logic [1:0] {
    LAT_CLS_FMA   = 2'd0,
    LAT_CLS_ARITH = 2'd1,
    LAT_CLS_ONE   = 2'd2
  } latClass_t;

  localparam logic [4:0] F5_FADD     = 5'b00000;
  localparam logic [4:0] F5_FSUB     = 5'b00001;
  localparam logic [4:0] F5_FMUL     = 5'b00010;
  localparam logic [4:0] F5_FDIV     = 5'b00011;
  localparam logic [4:0] F5_FSQRT    = 5'b01011;
  localparam logic [4:0] F5_FCMP     = 5'b10100;
  localparam logic [4:0] F5_FMV_X_W  = 5'b11100;
  localparam logic [4:0] F5_FCVT_W_S = 5'b11000;

  localparam logic [2:0] RM_RSV5 = 3'b101;
  localparam logic [2:0] RM_RSV6 = 3'b110;
  localparam logic [2:0] RM_DYN  = 3'b111;

  // DYN is only meaningful in the instruction field; once resolved it is as invalid as 101/110.
  function automatic logic rmIsReserved(input logic [2:0] rm);
    return (rm == RM_RSV5) || (rm == RM_RSV6) || (rm == RM_DYN);
  endfunction

endpackage

// File: rtl/fpu_op_decode.sv
// Combinational FP instruction decode: latency class, int-destination flag, legality, resolved rm.
// Zero latency, no state, no backpressure.
module fpu_op_decode
  import fpu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [2:0]  frm,
  output logic [1:0]  latClass,
  output logic        toInt,
  output logic        illegal,
  output logic [2:0]  rm
);

  logic [4:0] funct5;
  logic [2:0] rmField;
  logic       isFma;
  logic       unusedInstrBits;

  assign funct5  = instr[31:27];
  assign rmField = instr[14:12];
  // The four fused multiply-add opcodes are the only FP opcodes with bit 4 clear.
  assign isFma   = ~instr[4];
  assign rm      = (rmField == RM_DYN) ? frm : rmField;
  assign unusedInstrBits = ^{instr[26:15], instr[11:5], instr[3:0]};

  always_comb begin
    latClass = LAT_CLS_ONE;
    toInt    = 1'b0;
    illegal  = rmIsReserved(rm);
    if (isFma) begin
      latClass = LAT_CLS_FMA;
    end else begin
      case (funct5)
        F5_FADD, F5_FSUB, F5_FMUL:         latClass = LAT_CLS_ARITH;
        F5_FDIV, F5_FSQRT:                 illegal  = 1'b1;
        F5_FCMP, F5_FMV_X_W, F5_FCVT_W_S:  toInt    = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fpu_sequencer.sv
// Single-outstanding FP sequencer: accept -> EXEC for the op latency (+ FPU stalls) -> RESP until taken.
// Result at T+L+1 unstalled; fpuBusy_i holds the counter, rspReady_i low holds RESP, flush_i kills.
module fpu_sequencer
  import fpu_pkg::*;
#(
  parameter int LAT_FMA   = 3,
  parameter int LAT_ARITH = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        reqValid_i,
  output logic        reqReady_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rs3_i,
  input  logic [2:0]  frm_i,
  input  logic        flush_i,
  output logic        fpuEnable_o,
  output logic [31:0] fpuInstr_o,
  output logic [31:0] fpuRs1_o,
  output logic [31:0] fpuRs2_o,
  output logic [31:0] fpuRs3_o,
  output logic [2:0]  fpuRm_o,
  input  logic [31:0] fpuOut_i,
  input  logic        fpuBusy_i,
  output logic        rspValid_o,
  input  logic        rspReady_i,
  output logic [31:0] rspData_o,
  output logic [4:0]  rspRd_o,
  output logic        rspToInt_o,
  output logic        rspIllegal_o
);

  localparam int MAX_LAT = (LAT_FMA > LAT_ARITH) ? LAT_FMA : LAT_ARITH;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  seqState_t        state;
  seqState_t        stateNext;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       decLatClass;
  logic             decToInt;
  logic             decIllegal;
  logic [2:0]       decRm;
  logic             opToInt;
  logic             opIllegal;
  logic             accept;
  logic             execDone;

  fpu_op_decode uDecode (
    .instr    (instr_i),
    .frm      (frm_i),
    .latClass (decLatClass),
    .toInt    (decToInt),
    .illegal  (decIllegal),
    .rm       (decRm)
  );

  function automatic logic [CNT_W-1:0] latCycles(input logic [1:0] cls);
    case (latClass_t'(cls))
      LAT_CLS_FMA:   latCycles = CNT_W'(LAT_FMA);
      LAT_CLS_ARITH: latCycles = CNT_W'(LAT_ARITH);
      default:       latCycles = CNT_W'(1);
    endcase
  endfunction

  assign accept   = reqValid_i && (state == ST_IDLE) && !flush_i;
  assign execDone = (state == ST_EXEC) && !fpuBusy_i && (cnt == CNT_W'(1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // flush_i outranks both the response handshake and completion.
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: if (accept)                      stateNext = ST_EXEC;
      ST_EXEC: if (flush_i)                     stateNext = ST_IDLE;
               else if (execDone)               stateNext = ST_RESP;
      ST_RESP: if (flush_i || rspReady_i)       stateNext = ST_IDLE;
      default:                                  stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    reqReady_o  = (state == ST_IDLE);
    fpuEnable_o = (state == ST_EXEC);
    rspValid_o  = (state == ST_RESP);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt          <= '0;
      fpuInstr_o   <= '0;
      fpuRs1_o     <= '0;
      fpuRs2_o     <= '0;
      fpuRs3_o     <= '0;
      fpuRm_o      <= '0;
      opToInt      <= 1'b0;
      opIllegal    <= 1'b0;
      rspData_o    <= '0;
      rspRd_o      <= '0;
      rspToInt_o   <= 1'b0;
      rspIllegal_o <= 1'b0;
    end else begin
      if (accept) begin
        cnt        <= latCycles(decLatClass);
        fpuInstr_o <= instr_i;
        fpuRs1_o   <= rs1_i;
        fpuRs2_o   <= rs2_i;
        fpuRs3_o   <= rs3_i;
        fpuRm_o    <= decRm;
        opToInt    <= decToInt;
        opIllegal  <= decIllegal;
      end else if ((state == ST_EXEC) && !fpuBusy_i && !flush_i) begin
        cnt <= cnt - CNT_W'(1);
      end
      // Illegal ops still run their slot so timing is uniform, but report zero.
      if (execDone && !flush_i) begin
        rspData_o    <= opIllegal ? 32'h0 : fpuOut_i;
        rspRd_o      <= fpuInstr_o[11:7];
        rspToInt_o   <= opToInt;
        rspIllegal_o <= opIllegal;
      end
    end
  end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Scoreboard bench for fpu_sequencer: a stimulus process plans each transaction from the ISA rules,
// a negedge monitor checks every presented response against the queued expectation.
module tb_fpu_sequencer;

  localparam int TB_LAT_FMA   = 3;
  localparam int TB_LAT_ARITH = 2;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        reqValid_i = 1'b0;
  logic        reqReady_o;
  logic [31:0] instr_i = '0, rs1_i = '0, rs2_i = '0, rs3_i = '0;
  logic [2:0]  frm_i = '0;
  logic        flush_i = 1'b0;
  logic        fpuEnable_o;
  logic [31:0] fpuInstr_o, fpuRs1_o, fpuRs2_o, fpuRs3_o;
  logic [2:0]  fpuRm_o;
  logic [31:0] fpuOut_i = '0;
  logic        fpuBusy_i = 1'b0;
  logic        rspValid_o;
  logic        rspReady_i = 1'b0;
  logic [31:0] rspData_o;
  logic [4:0]  rspRd_o;
  logic        rspToInt_o, rspIllegal_o;

  fpu_sequencer #(.LAT_FMA(TB_LAT_FMA), .LAT_ARITH(TB_LAT_ARITH)) dut (
    .clk_i(clk), .reset_i(reset_i), .reqValid_i(reqValid_i), .reqReady_o(reqReady_o),
    .instr_i(instr_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rs3_i(rs3_i), .frm_i(frm_i),
    .flush_i(flush_i), .fpuEnable_o(fpuEnable_o), .fpuInstr_o(fpuInstr_o),
    .fpuRs1_o(fpuRs1_o), .fpuRs2_o(fpuRs2_o), .fpuRs3_o(fpuRs3_o), .fpuRm_o(fpuRm_o),
    .fpuOut_i(fpuOut_i), .fpuBusy_i(fpuBusy_i), .rspValid_o(rspValid_o),
    .rspReady_i(rspReady_i), .rspData_o(rspData_o), .rspRd_o(rspRd_o),
    .rspToInt_o(rspToInt_o), .rspIllegal_o(rspIllegal_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nCmp = 0;
  int nBad = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        toInt;
    logic        ill;
    int          validCyc;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   txnId  = 0;
  int   seenId = -1;

  localparam logic [6:0] OP_FP = 7'b1010011;
  localparam logic [6:0] OP_FMADD = 7'b1000011;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rules, stated in ISA terms.
  function automatic int refLatency(input logic [31:0] ins);
    logic [4:0] f5;
    f5 = ins[31:27];
    if (ins[6:0] inside {7'h43, 7'h47, 7'h4B, 7'h4F}) return TB_LAT_FMA;
    if (f5 inside {5'd0, 5'd1, 5'd2}) return TB_LAT_ARITH;
    return 1;
  endfunction

  function automatic logic [2:0] refRm(input logic [31:0] ins, input logic [2:0] frm);
    logic [2:0] f3;
    f3 = ins[14:12];
    return (f3 == 3'd7) ? frm : f3;
  endfunction

  function automatic logic refIllegal(input logic [31:0] ins, input logic [2:0] frm);
    logic [4:0] f5;
    logic [2:0] r;
    f5 = ins[31:27];
    r = refRm(ins, frm);
    if (r >= 3'd5) return 1'b1;
    return (ins[6:0] == OP_FP) && (f5 == 5'd3 || f5 == 5'd11);
  endfunction

  function automatic logic refToInt(input logic [31:0] ins);
    logic [4:0] f5;
    f5 = ins[31:27];
    return (ins[6:0] == OP_FP) && (f5 inside {5'd20, 5'd28, 5'd24});
  endfunction

  // stallMode: 0 none, 1 random, 2 busy in the first two EXEC cycles.
  task automatic runTxn(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [2:0] frm, input logic [31:0] result,
                        input int stallMode, input int hold, input int flushAt, input bit resetInResp);
    bit   busyPlan[$];
    int   nonBusy, k, lat, doneIdx, waited, t;
    logic [2:0] eRm;
    logic eIll;
    exp_t e;
    lat = refLatency(ins);
    eRm = refRm(ins, frm);
    eIll = refIllegal(ins, frm);
    nonBusy = 0;
    k = 0;
    while (nonBusy < lat) begin
      bit bz;
      if (stallMode == 2) bz = (k < 2);
      else if (stallMode == 1) bz = (k < 12) && ($urandom_range(0, 2) == 0);
      else bz = 1'b0;
      busyPlan.push_back(bz);
      if (!bz) nonBusy++;
      k++;
    end
    doneIdx = busyPlan.size();

    reqValid_i = 1'b1;
    instr_i = ins; rs1_i = a; rs2_i = b; rs3_i = c; frm_i = frm;
    waited = 0;
    while (reqReady_o !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    if (reqReady_o !== 1'b1) begin
      check("accept_timeout", {reqReady_o}, 1);
      reqValid_i = 1'b0;
      return;
    end
    t = cyc;
    e.data = eIll ? 32'h0 : result;
    e.rd = ins[11:7];
    e.toInt = refToInt(ins);
    e.ill = eIll;
    e.validCyc = t + doneIdx + 1;
    e.id = txnId++;
    sb.push_back(e);
    tick();
    reqValid_i = 1'b0;
    instr_i = $urandom; rs1_i = $urandom; rs2_i = $urandom; rs3_i = $urandom;
    frm_i = 3'($urandom);

    for (int i = 1; i <= doneIdx; i++) begin
      fpuBusy_i = busyPlan[i-1];
      fpuOut_i = (i == doneIdx) ? result : ~result;
      flush_i = (i == flushAt);
      check("exec_status", {fpuEnable_o, reqReady_o, rspValid_o}, 3'b100);
      check("fpu_drive", {fpuInstr_o, fpuRs1_o, fpuRs2_o, fpuRs3_o, fpuRm_o}, {ins, a, b, c, eRm});
      if (i == flushAt) begin
        tick();
        flush_i = 1'b0;
        fpuBusy_i = 1'b0;
        check("after_flush", {rspValid_o, fpuEnable_o, reqReady_o}, 3'b001);
        void'(sb.pop_back());
        return;
      end
      tick();
    end
    fpuBusy_i = 1'b0;
    fpuOut_i = $urandom;
    check("enable_off_in_resp", {fpuEnable_o}, 0);

    if (resetInResp) begin
      tick();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      check("reset_in_resp_status", {rspValid_o, fpuEnable_o, reqReady_o}, 3'b001);
      check("reset_in_resp_regs", {rspData_o, rspRd_o, rspToInt_o, rspIllegal_o, fpuInstr_o, fpuRm_o}, 0);
      void'(sb.pop_back());
      return;
    end

    for (int h = 0; h < hold; h++) begin
      check("ready_low_in_resp", {reqReady_o}, 0);
      tick();
    end
    rspReady_i = 1'b1;
    check("bubble_before_idle", {reqReady_o}, 0);
    tick();
    rspReady_i = 1'b0;
    check("idle_after_handshake", {reqReady_o, rspValid_o}, 2'b10);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rspValid_o === 1'b1) begin
      if (sb.size() == 0) begin
        nCmp++;
        nBad++;
        $display("FAIL unexpected_rsp: rspValid_o=1 with no outstanding request (cycle %0d)", cyc);
      end else begin
        e = sb[0];
        if (e.id != seenId) begin
          seenId = e.id;
          check("rsp_valid_cycle", cyc, e.validCyc);
        end
        check("rsp_payload", {rspData_o, rspRd_o, rspToInt_o, rspIllegal_o},
              {e.data, e.rd, e.toInt, e.ill});
        if (rspReady_i === 1'b1) void'(sb.pop_front());
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  function automatic logic [31:0] genInstr();
    logic [4:0] f5tab [12];
    logic [4:0] f5;
    logic [6:0] opc;
    f5tab = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd11, 5'd4, 5'd5, 5'd20, 5'd28, 5'd24, 5'd26, 5'd30};
    if ($urandom_range(0, 9) < 3) begin
      opc = OP_FMADD + 7'($urandom_range(0, 3) * 4);
      f5 = 5'($urandom);
    end else begin
      opc = OP_FP;
      f5 = f5tab[$urandom_range(0, 11)];
    end
    return {f5, 2'b00, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
  endfunction

  initial begin : stimulus
    logic [31:0] ins;
    int fl;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready_during_reset", {reqReady_o}, 1);
    reset_i = 1'b0;
    tick();
    check("reset_status", {reqReady_o, fpuEnable_o, rspValid_o, rspToInt_o, rspIllegal_o}, 5'b10000);
    check("reset_regs", {rspData_o, rspRd_o, fpuInstr_o, fpuRs1_o, fpuRs2_o, fpuRs3_o, fpuRm_o}, 0);

    runTxn(32'h002081D3, 32'h3F800000, 32'h40000000, 32'h0, 3'b000, 32'h40400000, 0, 0, 0, 0);
    runTxn({5'd3, 2'b00, 5'd2, 5'd1, 3'b000, 5'd4, OP_FMADD}, 32'h11, 32'h22, 32'h33, 3'b000,
           32'hCAFE0001, 2, 0, 0, 0);
    runTxn({5'd0, 2'b00, 5'd2, 5'd1, 3'b111, 5'd5, OP_FP}, 32'h1, 32'h2, 32'h0, 3'b010,
           32'h12345678, 0, 1, 0, 0);
    runTxn({5'd0, 2'b00, 5'd2, 5'd1, 3'b111, 5'd5, OP_FP}, 32'h1, 32'h2, 32'h0, 3'b101,
           32'h12345678, 0, 0, 0, 0);
    runTxn({5'd20, 2'b00, 5'd2, 5'd1, 3'b010, 5'd10, OP_FP}, 32'h3F800000, 32'h3F800000, 32'h0,
           3'b000, 32'h00000001, 0, 4, 0, 0);
    runTxn({5'd2, 2'b00, 5'd2, 5'd1, 3'b000, 5'd6, OP_FP}, 32'h5, 32'h6, 32'h0, 3'b000,
           32'hBEEF0000, 0, 0, 2, 0);
    tick();
    runTxn({5'd3, 2'b00, 5'd2, 5'd1, 3'b000, 5'd7, OP_FP}, 32'h40800000, 32'h40000000, 32'h0,
           3'b000, 32'h40000000, 0, 0, 0, 0);
    runTxn(32'h002081D3, 32'hAAAA5555, 32'h5555AAAA, 32'h0, 3'b000, 32'h87654321, 0, 2, 0, 1);

    for (int n = 0; n < 150; n++) begin
      ins = genInstr();
      fl = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      runTxn(ins, $urandom, $urandom, $urandom, 3'($urandom), $urandom, 1,
             $urandom_range(0, 3), fl, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
